stream_acc32: RTL and testbench
===============================

// Module: stream_acc32
// PURPOSE
// - Streaming accumulator that sits downstream of the team's 32-bit carry-lookahead adder datapath.
// - Consumes a packet of W-bit words over a valid/ready stream and sums them with an internal W-bit adder.
// - Tracks the carries out of the adder and returns the packet total plus its carry count on an output stream.
// - Used wherever multi-word sums are needed without widening the adder.
// PARAMETERS
// - W      32  data/accumulator width (adder width)
// - CNT_W  8   width of the carry counter and the beat counter
// PORTS
// - clk            in   1      single clock, rising edge
// - rst            in   1      synchronous, active-high reset
// - clear          in   1      synchronous abort; drops the packet in progress
// - in_valid       in   1      input word valid
// - in_ready       out  1      block can accept a word
// - in_data        in   W      word to add
// - in_last        in   1      final word of the packet
// - out_valid      out  1      result valid
// - out_ready      in   1      consumer accepts the result
// - out_sum        out  W      packet sum modulo 2^W (clamped when SAT_EN is set)
// - out_carry_cnt  out  CNT_W  number of adder carry-outs in the packet; saturates
// - out_beats      out  CNT_W  number of words accepted; saturates
// - out_ovf        out  1      1 when out_carry_cnt != 0
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-high.
// - Reset values:
//   - FSM = IDLE, in_ready = 1, out_valid = 0
//   - acc, carry_cnt, beats, out_sum, out_carry_cnt, out_beats = 0
//   - out_ovf = 0
// - FSM states: IDLE, ACCUM, DONE.
//   - IDLE/ACCUM: in_ready = 1 and out_valid = 0.
//   - DONE: in_ready = 0 and out_valid = 1.
// - A beat is accepted when in_valid & in_ready. On acceptance:
//   - {c, s} = acc + in_data (W+1-bit add, carry-in 0)
//   - acc <= s
//   - carry_cnt <= carry_cnt + c, held at 2^CNT_W-1
//   - beats <= beats + 1, held at 2^CNT_W-1
// - Transitions:
//   - IDLE -> ACCUM on an accepted beat with in_last = 0.
//   - IDLE or ACCUM -> DONE on an accepted beat with in_last = 1. A one-word packet is legal.
//   - When entering DONE, the out_* registers load the updated values, so the result includes the last beat.
//   - out_valid rises the cycle after the last beat is accepted (latency 1).
//   - DONE -> IDLE on out_valid & out_ready. acc, carry_cnt and beats clear in that same cycle.
//   - A new packet can be accepted the following cycle.
// - Output stability: out_* hold stable while out_valid = 1 and out_ready = 0.
// - Priority is rst > clear > handshake.
//   - clear in any state: go to IDLE, zero acc/carry_cnt/beats, drop out_valid.
//   - The beat presented in that cycle is not accepted, even if in_valid = 1.
// - Carry counter wrap is not allowed: it saturates at 2^CNT_W-1 and out_ovf stays 1.
// CONFIGURATION
// - Optional macro STREAM_ACC_SAT_EN.
// - Defined:
//   - On any beat with c = 1, or when acc is already saturated, acc <= {W{1'b1}}.
//   - out_sum therefore clamps at 2^W-1. carry_cnt still counts.
// - Undefined:
//   - acc wraps modulo 2^W (plain adder behaviour).
// - Ports are identical in both builds.
// TESTING
// - 4-beat packet 1,2,3,4 (last on beat 4), out_ready = 1:
//   - out_sum = 10, carry_cnt = 0, beats = 4, ovf = 0
//   - out_valid high for 1 cycle, exactly 1 clk after beat 4
// - Packet 0xFFFF_FFFF, 0x0000_0002 (last):
//   - no SAT_EN: out_sum = 0x0000_0001, carry_cnt = 1, ovf = 1
//   - SAT_EN: out_sum = 0xFFFF_FFFF
// - Backpressure: result ready with out_ready = 0 for 5 cycles.
//   - in_ready = 0 throughout; out_* stable
//   - in_valid beats offered in that window are not consumed
// - Single-beat packet 0x1234 with in_last = 1 straight from IDLE:
//   - out_sum = 0x1234, beats = 1
// - Mid-packet clear:
//   - Accept 5, 6; assert clear while a beat 7 is presented; then send packet 9 (last).
//   - out_sum = 9, beats = 1, and beat 7 is not counted.
// - Saturation: 300 beats of 0xFFFF_FFFF, CNT_W = 8.
//   - carry_cnt = 255, beats = 255, ovf = 1
//   - Assert rst mid-packet: all outputs return to reset values next clk.

Source files
------------

// File: rtl/stream_acc32.sv
// Streaming packet accumulator: sums W-bit words per packet and counts the adder carry-outs.
// Optional macro STREAM_ACC_SAT_EN clamps the running sum at 2^W-1 instead of wrapping.
module stream_acc32 #(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [CNT_W-1:0] out_carry_cnt,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_carry_cnt_q, out_carry_cnt_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic [W:0]       add_w;
  logic             carry;
  logic [W-1:0]     acc_nxt;
  logic [CNT_W-1:0] carry_cnt_nxt;
  logic [CNT_W-1:0] beats_nxt;
  logic             accept;

  assign in_ready      = (state_q != DONE);
  assign out_valid     = (state_q == DONE);
  assign out_sum       = out_sum_q;
  assign out_carry_cnt = out_carry_cnt_q;
  assign out_beats     = out_beats_q;
  assign out_ovf       = (out_carry_cnt_q != '0);

  // clear wins over the handshake, so a beat offered alongside it is dropped
  assign accept = in_valid & in_ready & ~clear;

  always_comb begin
    add_w = {1'b0, acc_q} + {1'b0, in_data};
    carry = add_w[W];
`ifdef STREAM_ACC_SAT_EN
    acc_nxt = (carry || (acc_q == '1)) ? '1 : add_w[W-1:0];
`else
    acc_nxt = add_w[W-1:0];
`endif
    carry_cnt_nxt = (carry && (carry_cnt_q != '1)) ? carry_cnt_q + CNT_W'(1) : carry_cnt_q;
    beats_nxt     = (beats_q != '1) ? beats_q + CNT_W'(1) : beats_q;
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    carry_cnt_d     = carry_cnt_q;
    beats_d         = beats_q;
    out_sum_d       = out_sum_q;
    out_carry_cnt_d = out_carry_cnt_q;
    out_beats_d     = out_beats_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      carry_cnt_d = '0;
      beats_d     = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d       = acc_nxt;
            carry_cnt_d = carry_cnt_nxt;
            beats_d     = beats_nxt;
            if (in_last) begin
              // result registers take the post-add values so the last beat is included
              state_d         = DONE;
              out_sum_d       = acc_nxt;
              out_carry_cnt_d = carry_cnt_nxt;
              out_beats_d     = beats_nxt;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            carry_cnt_d = '0;
            beats_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      carry_cnt_q     <= '0;
      beats_q         <= '0;
      out_sum_q       <= '0;
      out_carry_cnt_q <= '0;
      out_beats_q     <= '0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      carry_cnt_q     <= carry_cnt_d;
      beats_q         <= beats_d;
      out_sum_q       <= out_sum_d;
      out_carry_cnt_q <= out_carry_cnt_d;
      out_beats_q     <= out_beats_d;
    end
  end

endmodule

// File: tb/tb_stream_acc32.sv
// Directed bench for stream_acc32; expected values are hand-computed per scenario.
module tb_stream_acc32;
  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_sum;
  logic [7:0]  out_carry_cnt, out_beats;
  int errors = 0;
  int checks = 0;

  stream_acc32 #(.W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry_cnt(out_carry_cnt), .out_beats(out_beats), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({out_sum, out_carry_cnt, out_beats, out_ovf} !== 49'd0) begin errors++;
      $display("FAIL reset_outputs: sum=%h cc=%0d beats=%0d ovf=%b want all 0", out_sum, out_carry_cnt, out_beats, out_ovf); end
  endtask

  task automatic test_basic_sum();
    out_ready = 1'b1;
    drive_beat(32'd1, 1'b0); drive_beat(32'd2, 1'b0); drive_beat(32'd3, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    drive_beat(32'd4, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 32'd10) begin errors++; $display("FAIL basic_sum: got %0d want 10", out_sum); end
    checks++; if (out_carry_cnt !== 8'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL basic_carry: got cc=%0d ovf=%b want 0/0", out_carry_cnt, out_ovf); end
    checks++; if (out_beats !== 8'd4) begin errors++; $display("FAIL basic_beats: got %0d want 4", out_beats); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
  endtask

  task automatic test_carry();
    logic [31:0] exp_sum;
`ifdef STREAM_ACC_SAT_EN
    exp_sum = 32'hFFFF_FFFF;
`else
    exp_sum = 32'h0000_0001;
`endif
    drive_beat(32'hFFFF_FFFF, 1'b0); drive_beat(32'h0000_0002, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== exp_sum) begin errors++; $display("FAIL carry_sum: got %h want %h", out_sum, exp_sum); end
    checks++; if (out_carry_cnt !== 8'd1 || out_ovf !== 1'b1) begin errors++; $display("FAIL carry_cnt: got cc=%0d ovf=%b want 1/1", out_carry_cnt, out_ovf); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(32'd10, 1'b0); drive_beat(32'd20, 1'b0); drive_beat(32'd30, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== 32'd60) begin errors++; $display("FAIL bp_result: got v=%b sum=%0d want 1/60", out_valid, out_sum); end
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_hs[%0d]: got rdy=%b v=%b want 0/1", i, in_ready, out_valid); end
      checks++; if (out_sum !== 32'd60 || out_beats !== 8'd3 || out_carry_cnt !== 8'd0) begin errors++;
        $display("FAIL bp_stable[%0d]: got sum=%0d beats=%0d cc=%0d want 60/3/0", i, out_sum, out_beats, out_carry_cnt); end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_single_beat();
    drive_beat(32'h0000_1234, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== 32'h1234) begin errors++; $display("FAIL single_sum: got v=%b sum=%h want 1/1234", out_valid, out_sum); end
    checks++; if (out_beats !== 8'd1) begin errors++; $display("FAIL single_beats: got %0d want 1", out_beats); end
    tick();
  endtask

  task automatic test_clear();
    drive_beat(32'd5, 1'b0); drive_beat(32'd6, 1'b0);
    in_valid = 1'b1; in_data = 32'd7; in_last = 1'b0; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear_state: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    drive_beat(32'd9, 1'b1);
    checks++; if (out_sum !== 32'd9 || out_beats !== 8'd1) begin errors++; $display("FAIL clear_result: got sum=%0d beats=%0d want 9/1", out_sum, out_beats); end
    tick();
    out_ready = 1'b0;
    drive_beat(32'd1, 1'b1);
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_in_done: got v=%b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    logic [31:0] exp_sum;
`ifdef STREAM_ACC_SAT_EN
    exp_sum = 32'hFFFF_FFFF;
`else
    exp_sum = 32'hFFFF_FED4;
`endif
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = (i == 299);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_carry_cnt !== 8'd255 || out_ovf !== 1'b1) begin errors++; $display("FAIL sat_carry: got cc=%0d ovf=%b want 255/1", out_carry_cnt, out_ovf); end
    checks++; if (out_beats !== 8'd255) begin errors++; $display("FAIL sat_beats: got %0d want 255", out_beats); end
    checks++; if (out_sum !== exp_sum) begin errors++; $display("FAIL sat_sum: got %h want %h", out_sum, exp_sum); end
    tick();
    drive_beat(32'd7, 1'b0); drive_beat(32'd7, 1'b0); drive_beat(32'd7, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({out_sum, out_carry_cnt, out_beats, out_ovf} !== 49'd0) begin errors++;
      $display("FAIL rst_mid_outputs: sum=%h cc=%0d beats=%0d ovf=%b want all 0", out_sum, out_carry_cnt, out_beats, out_ovf); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_hs: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    drive_beat(32'd5, 1'b1);
    checks++; if (out_sum !== 32'd5 || out_beats !== 8'd1) begin errors++; $display("FAIL rst_mid_acc: got sum=%0d beats=%0d want 5/1", out_sum, out_beats); end
    tick();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_basic_sum();
    test_carry();
    test_backpressure();
    test_single_beat();
    test_clear();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
